control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Hardwired control sequencer for the mini-SRC CPU. It produces every datapath control strobe that the per-instruction testbenches currently drive by hand. It reads the IR, steps a Moore FSM through fetch (T0-T2) and a per-opcode execute sequence (T3-T7), and returns to fetch. It sits beside the datapath and drives its control inputs one-to-one.

Parameters:
OPC_W, 5, opcode field width (IR[31:27])
ALU_OP_W, 4, width of ALU_op output

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  synchronous active-low reset
IR  in  32  instruction register contents; opcode=IR[31:27]
CON_FF  in  1  branch condition flip-flop from datapath
Stop  in  1  halt request, sampled on last execute step
Run  out  1  1 while executing; 0 in reset/halt
PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out  out  1 each  bus-driver selects
MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable, ZHighIn, ZLowIn, R_in, CON_enable, OutPort_enable  out  1 each  register loads
IncPC, MDR_read, RAM_write, Gra, Grb, Grc  out  1 each  misc controls
ALU_op  out  ALU_OP_W  ALU function; valid when ZLowIn=1, else 0

Behaviour:
- Clock is the only clock. Clear is synchronous and active-low: Clear=0 sampled at posedge -> state RST, all outputs 0, Run=0. First posedge with Clear=1 -> T0.
- Clear=0 mid-instruction aborts at once. No RAM_write or R_in is issued after the abort edge.
- All outputs are registered decodes of the state (Moore). Each strobe is high for exactly one cycle, in the step listed. All unlisted outputs are 0.
- Fetch:
  - T0: PCout, MAR_enable, IncPC, PC_enable
  - T1: MDR_read, MDR_enable
  - T2: MDRout, IR_enable
  - The opcode is decoded from IR in T3, so IR must be stable from T3 until the end of the instruction.
- Execute sequences:
  - R-ALU (add,sub,and,or,shr,shl,ror,rol): T3 Grb,R_out,Y_enable; T4 Grc,R_out,ZLowIn,ALU_op; T5 ZLowout,Gra,R_in.
  - I-ALU (addi,andi,ori): T3 Grb,R_out,Y_enable; T4 Cout,ZLowIn,ALU_op (ADD/AND/OR); T5 ZLowout,Gra,R_in.
  - mul/div: T3 Gra,R_out,Y_enable; T4 Grb,R_out,ZLowIn,ZHighIn,ALU_op; T5 ZLowout,LO_enable; T6 ZHighout,HI_enable.
  - neg/not: T3 Grb,R_out,ZLowIn,ALU_op; T4 ZLowout,Gra,R_in.
  - ld: T3 Grb,BAout,Y_enable; T4 Cout,ZLowIn,ALU_op=ADD; T5 ZLowout,MAR_enable; T6 MDR_read,MDR_enable; T7 MDRout,Gra,R_in.
  - ldi: T3-T4 as ld; T5 ZLowout,Gra,R_in.
  - st: T3-T5 as ld; T6 Gra,R_out,MDR_enable (MDR_read=0); T7 RAM_write.
  - br: T3 Gra,R_out,CON_enable; T4 PCout,Y_enable; T5 Cout,ZLowIn,ALU_op=ADD; T6 ZLowout, plus PC_enable only if CON_FF=1 at that edge.
  - jr: T3 Gra,R_out,PC_enable.
  - jal: T3 PCout,Grb,R_in (Grb selects r15 per the ISA); T4 Gra,R_out,PC_enable.
  - in: T3 InPortout,Gra,R_in. out: T3 Gra,R_out,OutPort_enable.
  - mfhi: T3 HIout,Gra,R_in. mflo: T3 LOout,Gra,R_in.
  - nop, and any undefined opcode: no execute step; T2 -> T0.
  - halt: T3 -> HALT.
- After the final step of a sequence: go to HALT if Stop=1, else T0.
- HALT: all strobes 0, Run=0. Only Clear=0 leaves HALT.

Optional Feature:
Macro CU_SINGLE_STEP_EN.
- Defined: adds input port Step (1 bit). After each final step the FSM enters WAIT (Run=1, all strobes 0) and moves to T0 on the first cycle with Step=1. Stop still has priority and goes to HALT.
- Not defined: no Step port, no WAIT state; the FSM goes straight to T0.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, shr=00111, shl=01000, ror=01001, rol=01010, addi=01011, andi=01100, ori=01101, mul=01110, div=01111, neg=10000, not=10001, br=10010, jr=10011, jal=10100, in=10101, out=10110, mfhi=10111, mflo=11000, nop=11001, halt=11010
  - ALU_op encodings
  - state encoding
- One sub-module, ctrl_opclass_decode: combinational mapping of opcode -> instruction class and ALU_op, used by the FSM.

Test Plan:
- Clear=0 for 2 cycles, then 1 -> all outputs 0 and Run=0 during reset; T0 strobes (PCout, MAR_enable, IncPC, PC_enable) on the first cycle after release.
- IR=0x59080002 (addi r2,r1,2) -> T3 Grb,R_out,Y_enable; T4 Cout,ZLowIn,ALU_op=ADD; T5 ZLowout,Gra,R_in; next cycle T0; 6 cycles total.
- IR=0x00800055 (ld r1,0x55) -> T5 MAR_enable; T6 MDR_read+MDR_enable; T7 MDRout,Gra,R_in; RAM_write never asserted.
- IR=0x10800087 (st 0x87,r1) -> RAM_write high exactly one cycle, at T7; Clear=0 pulsed at T6 -> RAM_write never asserted.
- IR=0x9280000E (brzr r5,14) -> CON_enable at T3; with CON_FF=0 no PC_enable at T6; with CON_FF=1 PC_enable together with ZLowout at T6.
- IR=0xD0000000 (halt), or Stop=1 at the final step of add -> HALT, Run=0, no strobes for 20 cycles until Clear=0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types for the mini-SRC control sequencer: opcodes, ALU functions, instruction classes, FSM states.
// CU_SINGLE_STEP_EN adds the WAIT state used for single-step operation.
package cpu_ctrl_pkg;

  localparam int OPC_W    = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_SHR  = 5'b00111,
    OP_SHL  = 5'b01000, OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_ADDI = 5'b01011,
    OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110, OP_DIV  = 5'b01111,
    OP_NEG  = 5'b10000, OP_NOT  = 5'b10001, OP_BR   = 5'b10010, OP_JR   = 5'b10011,
    OP_JAL  = 5'b10100, OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
    OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010
  } opcode_e;

  // ALU_NOP is zero so ALU_op reads 0 whenever ZLowIn is idle.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,  ALU_AND = 4'd3,  ALU_OR  = 4'd4,
    ALU_SHR = 4'd5, ALU_SHL = 4'd6, ALU_ROR = 4'd7,  ALU_ROL = 4'd8,  ALU_MUL = 4'd9,
    ALU_DIV = 4'd10, ALU_NEG = 4'd11, ALU_NOT = 4'd12
  } alu_op_e;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_IALU, CLS_MULDIV, CLS_UNARY, CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } op_class_e;

  // T0..T7 must stay consecutive: the execute phase advances by incrementing the state.
  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT = 4'd10
`endif
  } state_e;

  function automatic state_e last_step(input op_class_e c);
    case (c)
      CLS_RALU, CLS_IALU, CLS_LDI: return S_T5;
      CLS_MULDIV, CLS_BR:          return S_T6;
      CLS_UNARY, CLS_JAL:          return S_T4;
      CLS_LD, CLS_ST:              return S_T7;
      CLS_NOP:                     return S_T2;
      default:                     return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the mini-SRC datapath (slave).
// CU_SINGLE_STEP_EN adds the Step input.
interface control_unit_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]         IR;
  logic                CON_FF;
  logic                Stop;
`ifdef CU_SINGLE_STEP_EN
  logic                Step;
`endif
  logic                Run;
  logic                PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out;
  logic                MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable;
  logic                ZHighIn, ZLowIn, R_in, CON_enable, OutPort_enable;
  logic                IncPC, MDR_read, RAM_write, Gra, Grb, Grc;
  logic [ALU_OP_W-1:0] ALU_op;

  modport master (
    input  IR, CON_FF, Stop,
`ifdef CU_SINGLE_STEP_EN
    input  Step,
`endif
    output Run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out,
    output MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable,
    output ZHighIn, ZLowIn, R_in, CON_enable, OutPort_enable,
    output IncPC, MDR_read, RAM_write, Gra, Grb, Grc, ALU_op
  );

  modport slave (
    output IR, CON_FF, Stop,
`ifdef CU_SINGLE_STEP_EN
    output Step,
`endif
    input  Run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out,
    input  MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable,
    input  ZHighIn, ZLowIn, R_in, CON_enable, OutPort_enable,
    input  IncPC, MDR_read, RAM_write, Gra, Grb, Grc, ALU_op
  );
endinterface

// File: rtl/control_unit_opclass_decode.sv
// Maps an opcode onto its execute-sequence class and ALU function; undefined opcodes behave as nop.
module ctrl_opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class,
  output alu_op_e          alu_op
);

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_NOP;
    case (opcode)
      OP_LD:   begin op_class = CLS_LD;     alu_op = ALU_ADD; end
      OP_LDI:  begin op_class = CLS_LDI;    alu_op = ALU_ADD; end
      OP_ST:   begin op_class = CLS_ST;     alu_op = ALU_ADD; end
      OP_ADD:  begin op_class = CLS_RALU;   alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_RALU;   alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_RALU;   alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_RALU;   alu_op = ALU_OR;  end
      OP_SHR:  begin op_class = CLS_RALU;   alu_op = ALU_SHR; end
      OP_SHL:  begin op_class = CLS_RALU;   alu_op = ALU_SHL; end
      OP_ROR:  begin op_class = CLS_RALU;   alu_op = ALU_ROR; end
      OP_ROL:  begin op_class = CLS_RALU;   alu_op = ALU_ROL; end
      OP_ADDI: begin op_class = CLS_IALU;   alu_op = ALU_ADD; end
      OP_ANDI: begin op_class = CLS_IALU;   alu_op = ALU_AND; end
      OP_ORI:  begin op_class = CLS_IALU;   alu_op = ALU_OR;  end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin op_class = CLS_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin op_class = CLS_UNARY;  alu_op = ALU_NOT; end
      OP_BR:   begin op_class = CLS_BR;     alu_op = ALU_ADD; end
      OP_JR:   op_class = CLS_JR;
      OP_JAL:  op_class = CLS_JAL;
      OP_IN:   op_class = CLS_IN;
      OP_OUT:  op_class = CLS_OUT;
      OP_MFHI: op_class = CLS_MFHI;
      OP_MFLO: op_class = CLS_MFLO;
      OP_HALT: op_class = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired mini-SRC sequencer: fetch T0-T2, per-class execute T3-T7, then T0 or HALT.
// CU_SINGLE_STEP_EN parks the FSM in WAIT after each instruction until Step is seen.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);

  state_e    state, next_state, done_state;
  op_class_e op_class;
  alu_op_e   alu_op_dec;
  logic      con_q;

  ctrl_opclass_decode u_decode (
    .opcode   (cu.IR[31:27]),
    .op_class (op_class),
    .alu_op   (alu_op_dec)
  );

  // con_q holds CON_FF as sampled on the edge that entered the current state.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= S_RST;
      con_q <= 1'b0;
    end else begin
      state <= next_state;
      con_q <= cu.CON_FF;
    end
  end

  always_comb begin
`ifdef CU_SINGLE_STEP_EN
    done_state = cu.Stop ? S_HALT : S_WAIT;
`else
    done_state = cu.Stop ? S_HALT : S_T0;
`endif
    next_state = state;
    case (state)
      S_RST:  next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T2;
      S_T2:   next_state = (op_class == CLS_NOP) ? done_state : S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (op_class == CLS_HALT)           next_state = S_HALT;
        else if (state == last_step(op_class)) next_state = done_state;
        else                                 next_state = state_e'(state + 4'd1);
      end
`ifdef CU_SINGLE_STEP_EN
      S_WAIT: if (cu.Step) next_state = S_T0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    cu.Run = 1'b0;
    cu.PCout = 1'b0; cu.ZLowout = 1'b0; cu.ZHighout = 1'b0; cu.MDRout = 1'b0; cu.HIout = 1'b0;
    cu.LOout = 1'b0; cu.InPortout = 1'b0; cu.BAout = 1'b0; cu.Cout = 1'b0; cu.R_out = 1'b0;
    cu.MAR_enable = 1'b0; cu.PC_enable = 1'b0; cu.MDR_enable = 1'b0; cu.IR_enable = 1'b0;
    cu.Y_enable = 1'b0; cu.HI_enable = 1'b0; cu.LO_enable = 1'b0; cu.ZHighIn = 1'b0;
    cu.ZLowIn = 1'b0; cu.R_in = 1'b0; cu.CON_enable = 1'b0; cu.OutPort_enable = 1'b0;
    cu.IncPC = 1'b0; cu.MDR_read = 1'b0; cu.RAM_write = 1'b0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0;
    cu.ALU_op = '0;

    cu.Run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin cu.PCout = 1'b1; cu.MAR_enable = 1'b1; cu.IncPC = 1'b1; cu.PC_enable = 1'b1; end
      S_T1: begin cu.MDR_read = 1'b1; cu.MDR_enable = 1'b1; end
      S_T2: begin cu.MDRout = 1'b1; cu.IR_enable = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (op_class)
          CLS_RALU, CLS_IALU: begin
            if (state == S_T3) begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.Y_enable = 1'b1; end
            if (state == S_T4) begin
              cu.ZLowIn = 1'b1;
              if (op_class == CLS_RALU) begin cu.Grc = 1'b1; cu.R_out = 1'b1; end
              else                        cu.Cout = 1'b1;
            end
            if (state == S_T5) begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
          end
          CLS_MULDIV: begin
            if (state == S_T3) begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.Y_enable = 1'b1; end
            if (state == S_T4) begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.ZLowIn = 1'b1; cu.ZHighIn = 1'b1; end
            if (state == S_T5) begin cu.ZLowout = 1'b1; cu.LO_enable = 1'b1; end
            if (state == S_T6) begin cu.ZHighout = 1'b1; cu.HI_enable = 1'b1; end
          end
          CLS_UNARY: begin
            if (state == S_T3) begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.ZLowIn = 1'b1; end
            if (state == S_T4) begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
          end
          // ld, ldi and st share the effective-address computation in T3-T5.
          CLS_LD, CLS_LDI, CLS_ST: begin
            if (state == S_T3) begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Y_enable = 1'b1; end
            if (state == S_T4) begin cu.Cout = 1'b1; cu.ZLowIn = 1'b1; end
            if (state == S_T5) begin
              cu.ZLowout = 1'b1;
              if (op_class == CLS_LDI) begin cu.Gra = 1'b1; cu.R_in = 1'b1; end
              else                        cu.MAR_enable = 1'b1;
            end
            if (state == S_T6) begin
              cu.MDR_enable = 1'b1;
              if (op_class == CLS_ST) begin cu.Gra = 1'b1; cu.R_out = 1'b1; end
              else                       cu.MDR_read = 1'b1;
            end
            if (state == S_T7) begin
              if (op_class == CLS_ST) cu.RAM_write = 1'b1;
              else begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
            end
          end
          CLS_BR: begin
            if (state == S_T3) begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.CON_enable = 1'b1; end
            if (state == S_T4) begin cu.PCout = 1'b1; cu.Y_enable = 1'b1; end
            if (state == S_T5) begin cu.Cout = 1'b1; cu.ZLowIn = 1'b1; end
            if (state == S_T6) begin cu.ZLowout = 1'b1; cu.PC_enable = con_q; end
          end
          CLS_JR:   begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.PC_enable = 1'b1; end
          CLS_JAL: begin
            if (state == S_T3) begin cu.PCout = 1'b1; cu.Grb = 1'b1; cu.R_in = 1'b1; end
            if (state == S_T4) begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.PC_enable = 1'b1; end
          end
          CLS_IN:   begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
          CLS_OUT:  begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.OutPort_enable = 1'b1; end
          CLS_MFHI: begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
          CLS_MFLO: begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    cu.ALU_op = cu.ZLowIn ? alu_op_dec : ALU_NOP;
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction strobe-table model.
// Builds with or without CU_SINGLE_STEP_EN (Step held high, so WAIT lasts one cycle).
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int PCO = 0,  ZLO = 1,  ZHO = 2,  MDRO = 3, HIO = 4,  LOO = 5,  INO = 6;
  localparam int BAO = 7,  CO = 8,   RO = 9,   MARE = 10, PCE = 11, MDRE = 12, IRE = 13;
  localparam int YE = 14,  HIE = 15, LOE = 16, ZHI = 17, ZLI = 18, RIN = 19, CONE = 20;
  localparam int OUTE = 21, INC = 22, MRD = 23, RWR = 24, GRA = 25, GRB = 26, GRC = 27;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit dut (.Clock(clk), .Clear(clear), .cu(bus));

  wire [27:0] obs = {bus.Grc, bus.Grb, bus.Gra, bus.RAM_write, bus.MDR_read, bus.IncPC,
                     bus.OutPort_enable, bus.CON_enable, bus.R_in, bus.ZLowIn, bus.ZHighIn,
                     bus.LO_enable, bus.HI_enable, bus.Y_enable, bus.IR_enable, bus.MDR_enable,
                     bus.PC_enable, bus.MAR_enable, bus.R_out, bus.Cout, bus.BAout, bus.InPortout,
                     bus.LOout, bus.HIout, bus.MDRout, bus.ZHighout, bus.ZLowout, bus.PCout};

  int n_checks = 0;
  int n_fails  = 0;
  logic [27:0] exp_v[$];
  logic [3:0]  exp_a[$];

  function automatic logic [27:0] b(input int i);
    return 28'(1) << i;
  endfunction

  function automatic void push(input logic [27:0] v, input logic [3:0] a);
    exp_v.push_back(v);
    exp_a.push_back(a);
  endfunction

  function automatic logic [3:0] model_alu(input logic [4:0] opc);
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18: return ALU_ADD;
      5'd4:          return ALU_SUB;
      5'd5, 5'd12:   return ALU_AND;
      5'd6, 5'd13:   return ALU_OR;
      5'd7:          return ALU_SHR;
      5'd8:          return ALU_SHL;
      5'd9:          return ALU_ROR;
      5'd10:         return ALU_ROL;
      5'd14:         return ALU_MUL;
      5'd15:         return ALU_DIV;
      5'd16:         return ALU_NEG;
      5'd17:         return ALU_NOT;
      default:       return 4'd0;
    endcase
  endfunction

  // Expected strobes for every cycle of one instruction, fetch included; returns 1 if it ends in HALT.
  function automatic bit build_seq(input logic [4:0] opc, input logic con, input logic stop);
    logic [3:0] a;
    bit halts;
    a = model_alu(opc);
    halts = stop || (opc == 5'd26);
    exp_v.delete();
    exp_a.delete();
    push(b(PCO) | b(MARE) | b(INC) | b(PCE), 0);
    push(b(MRD) | b(MDRE), 0);
    push(b(MDRO) | b(IRE), 0);
    if (opc inside {[5'd0:5'd2]}) begin
      push(b(GRB) | b(BAO) | b(YE), 0);
      push(b(CO) | b(ZLI), a);
      if (opc == 5'd1) push(b(ZLO) | b(GRA) | b(RIN), 0);
      else             push(b(ZLO) | b(MARE), 0);
      if (opc == 5'd0) begin
        push(b(MRD) | b(MDRE), 0);
        push(b(MDRO) | b(GRA) | b(RIN), 0);
      end else if (opc == 5'd2) begin
        push(b(GRA) | b(RO) | b(MDRE), 0);
        push(b(RWR), 0);
      end
    end else if (opc inside {[5'd3:5'd13]}) begin
      push(b(GRB) | b(RO) | b(YE), 0);
      if (opc <= 5'd10) push(b(GRC) | b(RO) | b(ZLI), a);
      else              push(b(CO) | b(ZLI), a);
      push(b(ZLO) | b(GRA) | b(RIN), 0);
    end else begin
      case (opc)
        5'd14, 5'd15: begin
          push(b(GRA) | b(RO) | b(YE), 0);
          push(b(GRB) | b(RO) | b(ZLI) | b(ZHI), a);
          push(b(ZLO) | b(LOE), 0);
          push(b(ZHO) | b(HIE), 0);
        end
        5'd16, 5'd17: begin
          push(b(GRB) | b(RO) | b(ZLI), a);
          push(b(ZLO) | b(GRA) | b(RIN), 0);
        end
        5'd18: begin
          push(b(GRA) | b(RO) | b(CONE), 0);
          push(b(PCO) | b(YE), 0);
          push(b(CO) | b(ZLI), a);
          push(b(ZLO) | (con ? b(PCE) : 28'd0), 0);
        end
        5'd19: push(b(GRA) | b(RO) | b(PCE), 0);
        5'd20: begin
          push(b(PCO) | b(GRB) | b(RIN), 0);
          push(b(GRA) | b(RO) | b(PCE), 0);
        end
        5'd21: push(b(INO) | b(GRA) | b(RIN), 0);
        5'd22: push(b(GRA) | b(RO) | b(OUTE), 0);
        5'd23: push(b(HIO) | b(GRA) | b(RIN), 0);
        5'd24: push(b(LOO) | b(GRA) | b(RIN), 0);
        5'd26: push(28'd0, 0);
        default: ;
      endcase
    end
`ifdef CU_SINGLE_STEP_EN
    if (!halts) push(28'd0, 0);
`endif
    return halts;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts in T0; leaves the bench in T0 of the next instruction, or in HALT.
  task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop,
                           input int abort_at, output bit halted);
    bus.IR = ir;
    bus.CON_FF = con;
    bus.Stop = stop;
    halted = build_seq(ir[31:27], con, stop);
    for (int i = 0; i < exp_v.size(); i++) begin
      n_checks++;
      if (obs !== exp_v[i] || bus.ALU_op !== exp_a[i] || bus.Run !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL step%0d ir=%h: strobes=%h alu=%0d run=%b, expected strobes=%h alu=%0d run=1",
                 i, ir, obs, bus.ALU_op, bus.Run, exp_v[i], exp_a[i]);
      end
      if (i == abort_at) begin
        clear = 1'b0;
        tick();
        n_checks++;
        if (obs !== 28'd0 || bus.Run !== 1'b0) begin
          n_fails++;
          $display("[TB] FAIL abort_reset ir=%h: strobes=%h run=%b, expected 0/0", ir, obs, bus.Run);
        end
        clear = 1'b1;
        tick();
        halted = 1'b0;
        return;
      end
      tick();
    end
    if (halted) begin
      n_checks++;
      if (obs !== 28'd0 || bus.Run !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL halt_entry ir=%h: strobes=%h run=%b, expected 0/0", ir, obs, bus.Run);
      end
    end
  endtask

  task automatic check_halt_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks++;
      if (obs !== 28'd0 || bus.Run !== 1'b0 || bus.ALU_op !== 4'd0) begin
        n_fails++;
        $display("[TB] FAIL halt_hold cyc%0d: strobes=%h run=%b alu=%0d, expected all 0",
                 i, obs, bus.Run, bus.ALU_op);
      end
    end
  endtask

  task automatic recover;
    clear = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== (b(PCO) | b(MARE) | b(INC) | b(PCE)) || bus.Run !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL recover_t0: strobes=%h run=%b, expected T0 strobes", obs, bus.Run);
    end
  endtask

  task automatic test_reset;
    clear = 1'b0;
    bus.IR = 32'hC8000000;
    bus.CON_FF = 1'b0;
    bus.Stop = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    bus.Step = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs !== 28'd0 || bus.Run !== 1'b0 || bus.ALU_op !== 4'd0) begin
        n_fails++;
        $display("[TB] FAIL reset_state cyc%0d: strobes=%h run=%b, expected 0/0", i, obs, bus.Run);
      end
    end
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== (b(PCO) | b(MARE) | b(INC) | b(PCE)) || bus.Run !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL reset_release_t0: strobes=%h run=%b, expected %h/1",
               obs, bus.Run, b(PCO) | b(MARE) | b(INC) | b(PCE));
    end
  endtask

  task automatic test_directed;
    bit h;
    run_instr(32'h59080002, 1'b0, 1'b0, -1, h);
    run_instr(32'h00800055, 1'b0, 1'b0, -1, h);
    run_instr(32'h10800087, 1'b0, 1'b0, -1, h);
  endtask

  task automatic test_st_abort;
    bit h;
    run_instr(32'h10800087, 1'b0, 1'b0, 6, h);
    run_instr(32'hC8000000, 1'b0, 1'b0, -1, h);
  endtask

  task automatic test_branch;
    bit h;
    run_instr(32'h9280000E, 1'b0, 1'b0, -1, h);
    run_instr(32'h9280000E, 1'b1, 1'b0, -1, h);
  endtask

  task automatic test_halt;
    bit h;
    run_instr(32'hD0000000, 1'b0, 1'b0, -1, h);
    check_halt_hold(20);
    recover();
    run_instr(32'h18C42000, 1'b0, 1'b1, -1, h);
    bus.Stop = 1'b0;
    check_halt_hold(20);
    recover();
  endtask

  task automatic test_random;
    bit h;
    logic [4:0]  opc;
    logic [31:0] ir;
    for (int n = 0; n < 80; n++) begin
      opc = 5'($urandom_range(0, 31));
      ir  = {opc, 27'($urandom)};
      run_instr(ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), -1, h);
      if (h) begin
        bus.Stop = 1'b0;
        check_halt_hold(3);
        recover();
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_st_abort();
    test_branch();
    test_halt();
    test_random();
    n_checks++;
    if (obs !== (b(PCO) | b(MARE) | b(INC) | b(PCE)) || bus.Run !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL final_t0: strobes=%h run=%b, expected T0 strobes", obs, bus.Run);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
